// File: rtl/gpu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_arb_pkg
// Description : Shared widths, FSM state encoding and write-payload type for
//               the GPU pixel-write arbiter and its round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_arb_pkg;

    localparam int PX_W    = 8;   // pixel byte width
    localparam int COORD_W = 6;   // column / row coordinate width

    // Arbiter FSM. CLEAR is only reachable when the clear engine is built in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        CLEAR = 2'd3
    } arb_state_t;

    // Registered GPU write payload; field order matches the GPU port order.
    typedef struct packed {
        logic [PX_W-1:0]    px;
        logic [COORD_W-1:0] column;
        logic [COORD_W-1:0] row;
        logic               palette;
        logic               overlay;
    } payload_t;

endpackage : gpu_arb_pkg
`default_nettype wire

// File: rtl/gpu_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : gpu_rr_picker
// Description : Purely combinational round-robin picker. Scans the request
//               vector starting one past the pointer (wrapping) and returns
//               the first valid requester as a one-hot grant plus its index.
// Ports       : i_valid  [NUM_REQ] request vector
//               i_ptr    [IDX_W]   last granted index
//               o_grant  [NUM_REQ] one-hot grant (all 0 when nothing valid)
//               o_idx    [IDX_W]   index of the granted requester
//               o_any              at least one requester valid
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_rr_picker
    import gpu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Two passes give wrap-around priority without modulo arithmetic:
    // first the indices above the pointer, then those at or below it.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_valid[i] && (i > int'(i_ptr))) begin
                o_any      = 1'b1;
                o_grant[i] = 1'b1;
                o_idx      = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_valid[i] && (i <= int'(i_ptr))) begin
                o_any      = 1'b1;
                o_grant[i] = 1'b1;
                o_idx      = IDX_W'(i);
            end
        end
    end

endmodule : gpu_rr_picker
`default_nettype wire

// File: rtl/gpu_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpu_write_arbiter
// Description : Shares the single GPU pixel-write port among NUM_REQ
//               requesters. Round-robin arbitration, one captured request in
//               flight, a registered 1-cycle write strobe issued only when the
//               GPU reports write_available, followed by a 1-cycle hold.
//               Optional full-screen clear engine, built when the macro
//               GPU_ARB_CLEAR_EN is defined.
// Ports       : clk, rst                  clock, synchronous active-high reset
//               req_valid/req_ready       per-requester handshake (ready one-hot)
//               req_px_data/column/row/palette/overlay  packed request payloads
//               clear_start/clear_px_data clear request pulse and fill value
//               clear_busy                clear sweep in progress
//               gpu_write_available       GPU can take a write this cycle
//               gpu_write, gpu_*          registered strobe and payload to GPU
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_write_arbiter
    import gpu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int COLS    = 64,
    parameter int ROWS    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*PX_W-1:0]    req_px_data,
    input  logic [NUM_REQ*COORD_W-1:0] req_column,
    input  logic [NUM_REQ*COORD_W-1:0] req_row,
    input  logic [NUM_REQ-1:0]         req_palette,
    input  logic [NUM_REQ-1:0]         req_overlay,
    input  logic                       clear_start,
    input  logic [PX_W-1:0]            clear_px_data,
    output logic                       clear_busy,
    input  logic                       gpu_write_available,
    output logic                       gpu_write,
    output logic [PX_W-1:0]            gpu_px_data,
    output logic [COORD_W-1:0]         gpu_column,
    output logic [COORD_W-1:0]         gpu_row,
    output logic                       gpu_palette,
    output logic                       gpu_overlay
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Pointer starts at the last requester so requester 0 wins first.
    localparam logic [IDX_W-1:0] c_ptr_rst = IDX_W'(NUM_REQ - 1);

    arb_state_t       r_state_q, w_state_d;
    logic [IDX_W-1:0] r_ptr_q,   w_ptr_d;
    payload_t         r_pl_q,    w_pl_d;
    logic             r_write_q, w_write_d;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;
    payload_t           w_req_pl;

    gpu_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_valid (req_valid),
        .i_ptr   (r_ptr_q),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Only the winner's payload slice is selected; others are never sampled.
    always_comb begin
        w_req_pl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_req_pl.px      = req_px_data[PX_W*i +: PX_W];
                w_req_pl.column  = req_column[COORD_W*i +: COORD_W];
                w_req_pl.row     = req_row[COORD_W*i +: COORD_W];
                w_req_pl.palette = req_palette[i];
                w_req_pl.overlay = req_overlay[i];
            end
        end
    end

`ifdef GPU_ARB_CLEAR_EN
    localparam logic [COORD_W-1:0] c_last_col = COORD_W'(COLS - 1);
    localparam logic [COORD_W-1:0] c_last_row = COORD_W'(ROWS - 1);

    logic               r_clr_pend_q, w_clr_pend_d;
    logic               r_clr_busy_q, w_clr_busy_d;
    logic [PX_W-1:0]    r_clr_px_q,   w_clr_px_d;
    logic [COORD_W-1:0] r_clr_col_q,  w_clr_col_d;
    logic [COORD_W-1:0] r_clr_row_q,  w_clr_row_d;
    logic               w_clr_accept;
    logic               w_clr_last;

    // A start while one is already pending or sweeping is dropped.
    assign w_clr_accept = clear_start && !r_clr_pend_q && !r_clr_busy_q;
    assign w_clr_last   = (r_clr_col_q == c_last_col) && (r_clr_row_q == c_last_row);
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        w_pl_d    = r_pl_q;
        w_write_d = 1'b0;
        req_ready = '0;
`ifdef GPU_ARB_CLEAR_EN
        w_clr_pend_d = r_clr_pend_q;
        w_clr_busy_d = r_clr_busy_q;
        w_clr_px_d   = r_clr_px_q;
        w_clr_col_d  = r_clr_col_q;
        w_clr_row_d  = r_clr_row_q;
`endif

        case (r_state_q)
            IDLE: begin
`ifdef GPU_ARB_CLEAR_EN
                // Clear (new or pending) outranks every requester.
                if (!rst && (r_clr_pend_q || w_clr_accept)) begin
                    w_state_d    = CLEAR;
                    w_clr_busy_d = 1'b1;
                    w_clr_pend_d = 1'b0;
                    w_clr_col_d  = '0;
                    w_clr_row_d  = '0;
                    w_clr_px_d   = r_clr_pend_q ? r_clr_px_q : clear_px_data;
                    w_pl_d       = '0;
                    w_pl_d.px    = w_clr_px_d;
                end else
`endif
                if (!rst && w_any) begin
                    req_ready = w_grant;
                    w_pl_d    = w_req_pl;
                    w_ptr_d   = w_idx;
                    w_state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (gpu_write_available) begin
                    w_write_d = 1'b1;
                    w_state_d = HOLD;
                end
            end

            HOLD: begin
                // One dead cycle lets the GPU drop write_available.
                w_state_d = IDLE;
`ifdef GPU_ARB_CLEAR_EN
                if (r_clr_busy_q) begin
                    if (w_clr_last) begin
                        w_clr_busy_d = 1'b0;
                    end else begin
                        if (r_clr_col_q == c_last_col) begin
                            w_clr_col_d = '0;
                            w_clr_row_d = r_clr_row_q + 1'b1;
                        end else begin
                            w_clr_col_d = r_clr_col_q + 1'b1;
                        end
                        w_pl_d        = '0;
                        w_pl_d.px     = r_clr_px_q;
                        w_pl_d.column = w_clr_col_d;
                        w_pl_d.row    = w_clr_row_d;
                        w_state_d     = CLEAR;
                    end
                end
`endif
            end

`ifdef GPU_ARB_CLEAR_EN
            CLEAR: begin
                if (gpu_write_available) begin
                    w_write_d = 1'b1;
                    w_state_d = HOLD;
                end
            end
`endif

            default: w_state_d = IDLE;
        endcase

`ifdef GPU_ARB_CLEAR_EN
        // A start arriving while busy with a requester write waits for IDLE.
        if ((r_state_q != IDLE) && w_clr_accept) begin
            w_clr_pend_d = 1'b1;
            w_clr_px_d   = clear_px_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_ptr_q   <= c_ptr_rst;
            r_pl_q    <= '0;
            r_write_q <= 1'b0;
`ifdef GPU_ARB_CLEAR_EN
            r_clr_pend_q <= 1'b0;
            r_clr_busy_q <= 1'b0;
            r_clr_px_q   <= '0;
            r_clr_col_q  <= '0;
            r_clr_row_q  <= '0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
            r_pl_q    <= w_pl_d;
            r_write_q <= w_write_d;
`ifdef GPU_ARB_CLEAR_EN
            r_clr_pend_q <= w_clr_pend_d;
            r_clr_busy_q <= w_clr_busy_d;
            r_clr_px_q   <= w_clr_px_d;
            r_clr_col_q  <= w_clr_col_d;
            r_clr_row_q  <= w_clr_row_d;
`endif
        end
    end

`ifdef GPU_ARB_CLEAR_EN
    assign clear_busy = r_clr_busy_q;
`else
    // Clear engine absent: its inputs and sweep dimensions have no effect.
    localparam int c_unused_dims = COLS + ROWS;
    logic w_unused_clr;
    assign w_unused_clr = ^{clear_start, clear_px_data};
    assign clear_busy   = 1'b0;
`endif

    assign gpu_write   = r_write_q;
    assign gpu_px_data = r_pl_q.px;
    assign gpu_column  = r_pl_q.column;
    assign gpu_row     = r_pl_q.row;
    assign gpu_palette = r_pl_q.palette;
    assign gpu_overlay = r_pl_q.overlay;

endmodule : gpu_write_arbiter
`default_nettype wire

// File: tb/tb_gpu_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_write_arbiter
// Description : Self-checking bench for gpu_write_arbiter. Directed scenarios
//               followed by a randomized phase, all checked against a
//               transaction-level reference model (round-robin winner,
//               in-flight write, strobe after an available cycle, hold).
//               Clear-engine scenario depends on GPU_ARB_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gpu_write_arbiter;
    import gpu_arb_pkg::*;

    localparam int N   = 2;
    localparam int PLW = PX_W + 2*COORD_W + 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N*PX_W-1:0]    req_px_data;
    logic [N*COORD_W-1:0] req_column;
    logic [N*COORD_W-1:0] req_row;
    logic [N-1:0]         req_palette;
    logic [N-1:0]         req_overlay;
    logic                 clear_start;
    logic [PX_W-1:0]      clear_px_data;
    logic                 clear_busy;
    logic                 avail;
    logic                 gpu_write;
    logic [PX_W-1:0]      gpu_px_data;
    logic [COORD_W-1:0]   gpu_column;
    logic [COORD_W-1:0]   gpu_row;
    logic                 gpu_palette;
    logic                 gpu_overlay;

    always #5 clk = ~clk;

    gpu_write_arbiter #(.NUM_REQ(N), .COLS(4), .ROWS(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_px_data         (req_px_data),
        .req_column          (req_column),
        .req_row             (req_row),
        .req_palette         (req_palette),
        .req_overlay         (req_overlay),
        .clear_start         (clear_start),
        .clear_px_data       (clear_px_data),
        .clear_busy          (clear_busy),
        .gpu_write_available (avail),
        .gpu_write           (gpu_write),
        .gpu_px_data         (gpu_px_data),
        .gpu_column          (gpu_column),
        .gpu_row             (gpu_row),
        .gpu_palette         (gpu_palette),
        .gpu_overlay         (gpu_overlay)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    bit             model_en = 1'b0;
    bit             m_have   = 1'b0;   // captured write not yet strobed
    bit             m_strobe = 1'b0;   // strobe expected in this cycle
    int             m_last   = N - 1;  // last granted requester
    logic [PLW-1:0] m_pl     = '0;     // payload the GPU port must show

    logic [N-1:0]   obs_ready;
    logic           obs_write;
    logic           obs_busy;
    logic [PLW-1:0] obs_pl;
    int             grants[$];
    int             strobes[$];

    function automatic int winner(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] px, input logic [5:0] col,
                           input logic [5:0] row, input logic pal, input logic ov);
        req_px_data[8*i +: 8] = px;
        req_column[6*i +: 6]  = col;
        req_row[6*i +: 6]     = row;
        req_palette[i]        = pal;
        req_overlay[i]        = ov;
    endtask

    // One clock: sample/check at negedge, advance the model at posedge.
    task automatic cycle();
        int w;
        @(negedge clk);
        obs_ready = req_ready;
        obs_write = gpu_write;
        obs_busy  = clear_busy;
        obs_pl    = {gpu_px_data, gpu_column, gpu_row, gpu_palette, gpu_overlay};
        w = -1;
        if (!rst && !m_have && !m_strobe) w = winner(req_valid, m_last);
        if (model_en) begin
            chk("ready", 32'(obs_ready), (w < 0) ? 32'd0 : (32'd1 << w));
            chk("write", 32'(obs_write), 32'(m_strobe));
            chk("payload", 32'(obs_pl), 32'(m_pl));
        end
        for (int i = 0; i < N; i++) if (obs_ready[i]) grants.push_back(i);
        if (obs_write) strobes.push_back(cyc);
        @(posedge clk);
        if (rst) begin
            m_have = 1'b0; m_strobe = 1'b0; m_last = N - 1; m_pl = '0;
        end else if (model_en) begin
            if (m_strobe) begin
                m_strobe = 1'b0;
            end else if (m_have) begin
                if (avail) begin m_have = 1'b0; m_strobe = 1'b1; end
            end else if (w >= 0) begin
                m_have = 1'b1;
                m_last = w;
                m_pl   = {req_px_data[8*w +: 8], req_column[6*w +: 6], req_row[6*w +: 6],
                          req_palette[w], req_overlay[w]};
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; avail = 1'b0;
        cycle();
        rst = 1'b0;
        grants.delete();
        strobes.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int n_str, n_rdy, n;
        rst = 1'b1; req_valid = '0; avail = 1'b0; clear_start = 1'b0; clear_px_data = '0;
        req_px_data = '0; req_column = '0; req_row = '0; req_palette = '0; req_overlay = '0;
        cycle(); cycle();
        rst = 1'b0; model_en = 1'b1;

        // Reset state
        cycle();
        chk("rst_ready", 32'(obs_ready), 0);
        chk("rst_write", 32'(obs_write), 0);
        chk("rst_payload", 32'(obs_pl), 0);
        chk("rst_busy", 32'(obs_busy), 0);

        // Single request from requester 0
        set_req(0, 8'h12, 6'd31, 6'd31, 1'b0, 1'b0);
        set_req(1, 8'h77, 6'd5, 6'd6, 1'b1, 1'b1);
        req_valid = 2'b01; avail = 1'b1;
        cycle();
        chk("t1_ready", 32'(obs_ready), 32'b01);
        req_valid = 2'b00;
        cycle();
        chk("t1_issue_ready", 32'(obs_ready), 0);
        chk("t1_issue_write", 32'(obs_write), 0);
        cycle();
        chk("t1_strobe", 32'(obs_write), 1);
        chk("t1_payload", 32'(obs_pl), 32'({8'h12, 6'd31, 6'd31, 1'b0, 1'b0}));
        cycle();
        chk("t1_strobe_end", 32'(obs_write), 0);

        // Two requesters held valid: alternate grants, strobes >= 3 apart
        do_reset();
        req_valid = 2'b11; avail = 1'b1;
        for (int k = 0; k < 40 && grants.size() < 4; k++) cycle();
        req_valid = 2'b00;
        repeat (6) cycle();
        chk("t2_ngrants", 32'(grants.size()), 4);
        for (int k = 0; k < grants.size() && k < 4; k++)
            chk($sformatf("t2_grant%0d", k), 32'(grants[k]), 32'(k % 2));
        chk("t2_nstrobes", 32'(strobes.size()), 4);
        for (int k = 1; k < strobes.size(); k++)
            chk($sformatf("t2_gap%0d", k), 32'(strobes[k] - strobes[k-1] >= 3), 1);

        // GPU unavailable for 20 cycles after transfer
        do_reset();
        req_valid = 2'b01; avail = 1'b0;
        cycle();
        req_valid = 2'b11;
        n_str = 0; n_rdy = 0;
        repeat (20) begin
            cycle();
            if (obs_write) n_str++;
            if (obs_ready != 0) n_rdy++;
        end
        chk("t3_nostrobe", 32'(n_str), 0);
        chk("t3_noready", 32'(n_rdy), 0);
        avail = 1'b1; req_valid = 2'b00;
        cycle();
        chk("t3_pre", 32'(obs_write), 0);
        avail = 1'b0;
        cycle();
        chk("t3_strobe", 32'(obs_write), 1);
        cycle();
        chk("t3_single", 32'(obs_write), 0);

        // Reset while waiting in ISSUE
        do_reset();
        set_req(0, 8'h5A, 6'd9, 6'd17, 1'b1, 1'b1);
        req_valid = 2'b01; avail = 1'b0;
        cycle();
        req_valid = 2'b00; rst = 1'b1; avail = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("t4_ready", 32'(obs_ready), 0);
        chk("t4_write", 32'(obs_write), 0);
        chk("t4_payload", 32'(obs_pl), 0);
        chk("t4_busy", 32'(obs_busy), 0);
        req_valid = 2'b11;
        cycle();
        chk("t4_first", 32'(obs_ready), 32'b01);
        req_valid = 2'b00;
        repeat (4) cycle();

`ifndef GPU_ARB_CLEAR_EN
        // Clear engine absent: start pulse is ignored
        do_reset();
        set_req(0, 8'h3C, 6'd1, 6'd2, 1'b0, 1'b1);
        req_valid = 2'b01; avail = 1'b1; clear_start = 1'b1; clear_px_data = 8'hAA;
        cycle();
        chk("t5_ready", 32'(obs_ready), 32'b01);
        chk("t5_busy0", 32'(obs_busy), 0);
        clear_start = 1'b0; req_valid = 2'b00;
        n = 0;
        repeat (5) begin
            cycle();
            if (obs_busy) n++;
        end
        chk("t5_busy_never", 32'(n), 0);
        chk("t5_nstrobes", 32'(strobes.size()), 1);
        chk("t5_payload", 32'(obs_pl), 32'({8'h3C, 6'd1, 6'd2, 1'b0, 1'b1}));
`else
        // Clear sweep of a 4x4 screen, then requester 0 served
        do_reset();
        set_req(0, 8'h3C, 6'd1, 6'd2, 1'b0, 1'b1);
        req_valid = 2'b01; avail = 1'b1; clear_start = 1'b1; clear_px_data = 8'hAA;
        model_en = 1'b0;
        cycle();
        chk("t5c_ready", 32'(obs_ready), 0);
        clear_start = 1'b0; clear_px_data = 8'h00;
        n = 0;
        for (int k = 0; k < 200 && n < 16; k++) begin
            cycle();
            chk("t5c_stall", 32'({obs_busy, obs_ready}), 32'({1'b1, 2'b00}));
            if (obs_write) begin
                chk($sformatf("t5c_px%0d", n), 32'(obs_pl),
                    32'({8'hAA, 6'(n % 4), 6'(n / 4), 2'b00}));
                n++;
            end
        end
        chk("t5c_count", 32'(n), 16);
        m_pl = {8'hAA, 6'd3, 6'd3, 2'b00}; m_have = 1'b0; m_strobe = 1'b0;
        model_en = 1'b1;
        cycle();
        chk("t5c_after_ready", 32'(obs_ready), 32'b01);
        chk("t5c_after_busy", 32'(obs_busy), 0);
        req_valid = 2'b00;
        repeat (4) cycle();
`endif

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            req_valid = N'($urandom);
            avail     = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++)
                set_req(i, 8'($urandom), 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
            cycle();
        end
        rst = 1'b0; req_valid = '0;
        repeat (5) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gpu_write_arbiter
`default_nettype wire
